// File: rtl/instruction_issue.sv
// instruction_issue: nRisc front end. Fetches a two-byte instruction,
// decodes it into operation/reg_a/reg_b/data, and offers it to the
// register-file stage over a valid/ready handshake.
// Branch redirects restart the fetch at a new pc.
// Define ISSUE_HAZARD_STALL_EN to build the single-entry writeback
// scoreboard and the STALL state. Together they hold back an instruction
// that reads a register still being written.
module instruction_issue #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           WB_LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [7:0]            imem_data,
  output logic [2:0]            operation,
  output logic [2:0]            reg_a,
  output logic [2:0]            reg_b,
  output logic [7:0]            data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target
);

  localparam logic [2:0] OpLi  = 3'b011;
  localparam logic [2:0] OpSw  = 3'b100;
  localparam logic [2:0] OpBeq = 3'b110;
  localparam logic [2:0] OpBnz = 3'b111;

  typedef enum logic [2:0] {
    StFetch0,
    StFetch1,
    StFetch2,
    StStall,
    StIssue
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [5:0]              byte0_q, byte0_d;   // byte0[7:2]; [1:0] carry no meaning
  logic [2:0]              operation_q, operation_d;
  logic [2:0]              reg_a_q, reg_a_d;
  logic [2:0]              reg_b_q, reg_b_d;
  logic [7:0]              data_q, data_d;
  logic                    issue_valid_q, issue_valid_d;

  logic                    handshake;
  logic                    hazard;

  // Decoded fields of the instruction completing in FETCH2 (byte1 arrives now).
  logic [2:0]              dec_op, dec_ra, dec_rb;

  assign dec_op    = byte0_q[5:3];
  assign dec_ra    = byte0_q[2:0];
  assign dec_rb    = imem_data[7:5];
  assign handshake = (state_q == StIssue) && issue_ready;

`ifdef ISSUE_HAZARD_STALL_EN
  localparam int unsigned CntW = (WB_LATENCY == 0) ? 1 : $clog2(WB_LATENCY + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      dest_q, dest_d;
  logic [2:0]      chk_op, chk_ra, chk_rb;

  // FETCH2 checks the instruction being decoded; STALL re-checks the held one.
  assign chk_op = (state_q == StFetch2) ? dec_op : operation_q;
  assign chk_ra = (state_q == StFetch2) ? dec_ra : reg_a_q;
  assign chk_rb = (state_q == StFetch2) ? dec_rb : reg_b_q;

  assign hazard = (cnt_q != '0) && (chk_op != OpLi) &&
                  ((chk_ra == dest_q) || (chk_rb == dest_q));

  // Scoreboard: count down the pending writeback, reload on a writing issue.
  always_comb begin
    cnt_d  = cnt_q;
    dest_d = dest_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
    if (handshake && (operation_q != OpSw) && (operation_q != OpBnz)) begin
      dest_d = (operation_q == OpBeq) ? 3'b001 : reg_a_q;
      cnt_d  = CntW'(WB_LATENCY);
    end
  end

  // Scoreboard registers; redirects leave them untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      dest_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dest_q <= dest_d;
    end
  end
`else
  logic [31:0] unused_wb_latency;

  assign unused_wb_latency = WB_LATENCY;
  assign hazard            = 1'b0;
`endif

  // Next-state and next-output logic for the fetch/decode/issue sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_addr_d   = imem_addr_q;
    byte0_d       = byte0_q;
    operation_d   = operation_q;
    reg_a_d       = reg_a_q;
    reg_b_d       = reg_b_q;
    data_d        = data_q;
    issue_valid_d = issue_valid_q;

    case (state_q)
      StFetch0: begin
        // pc is being read now; present pc+1 so byte1 lands in FETCH2.
        imem_addr_d = pc_q + ADDR_WIDTH'(1);
        state_d     = StFetch1;
      end
      StFetch1: begin
        byte0_d = imem_data[7:2];
        state_d = StFetch2;
      end
      StFetch2: begin
        operation_d = dec_op;
        reg_a_d     = dec_ra;
        reg_b_d     = dec_rb;
        data_d      = imem_data;
        if (hazard) begin
          state_d       = StStall;
          issue_valid_d = 1'b0;
        end else begin
          state_d       = StIssue;
          issue_valid_d = 1'b1;
        end
      end
`ifdef ISSUE_HAZARD_STALL_EN
      StStall: begin
        if (!hazard) begin
          state_d       = StIssue;
          issue_valid_d = 1'b1;
        end
      end
`endif
      StIssue: begin
        if (handshake) begin
          issue_valid_d = 1'b0;
          pc_d          = pc_q + ADDR_WIDTH'(2);
          imem_addr_d   = pc_q + ADDR_WIDTH'(2);
          state_d       = StFetch0;
        end
      end
      default: begin
        issue_valid_d = 1'b0;
        state_d       = StFetch0;
      end
    endcase

    // A taken branch overrides everything, including pc+2 from a handshake.
    if (redirect_valid) begin
      pc_d          = redirect_target;
      imem_addr_d   = redirect_target;
      issue_valid_d = 1'b0;
      state_d       = StFetch0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StFetch0;
      pc_q          <= RESET_PC;
      imem_addr_q   <= RESET_PC;
      byte0_q       <= '0;
      operation_q   <= '0;
      reg_a_q       <= '0;
      reg_b_q       <= '0;
      data_q        <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_addr_q   <= imem_addr_d;
      byte0_q       <= byte0_d;
      operation_q   <= operation_d;
      reg_a_q       <= reg_a_d;
      reg_b_q       <= reg_b_d;
      data_q        <= data_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign imem_addr   = imem_addr_q;
  assign operation   = operation_q;
  assign reg_a       = reg_a_q;
  assign reg_b       = reg_b_q;
  assign data        = data_q;
  assign issue_valid = issue_valid_q;

endmodule
